// File: rtl/button_press_classifier_pkg.sv
// Purpose : shared types for the button press classifier and its consumers.
// Contents: btn_state_e (3-bit classifier state encoding) and a helper that
//           says whether a state counts as "button held".
package btn_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESSED1  = 3'd1,
    WAIT2     = 3'd2,
    PRESSED2  = 3'd3,
    LONG_HELD = 3'd4
  } btn_state_e;

  function automatic logic state_is_held(btn_state_e s);
    return (s == PRESSED1) || (s == PRESSED2) || (s == LONG_HELD);
  endfunction

endpackage

// File: rtl/button_press_classifier_tick_divider.sv
// Purpose : free-running prescaler producing a one-cycle Tick every DIV clocks.
// Ports   : Clk     in  system clock
//           Reset_n in  synchronous active-low reset (counter restarts at 0)
//           Tick    out high for one Clk cycle every DIV cycles
module tick_divider #(
  parameter int DIV = 50000
) (
  input  logic Clk,
  input  logic Reset_n,
  output logic Tick
);

  localparam int W = $clog2(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign Tick = (cnt_q == LAST);

endmodule

// File: rtl/button_press_classifier.sv
// Purpose : classifies a debounced button level into single-cycle events
//           (short press, double click, long press, auto-repeat).
// Ports   : Clk, Reset_n (sync, active-low), Level (debounced, synchronous)
//           Held        high while in PRESSED1 / PRESSED2 / LONG_HELD
//           ShortPress, DoubleClick, LongPress, Repeat: registered 1-cycle pulses
//
// state     | meaning
// IDLE      | button released, nothing pending
// PRESSED1  | first press in progress, timing toward long press
// WAIT2     | released after first press, waiting for a second click
// PRESSED2  | second press of a double click, no further events
// LONG_HELD | long press reported, emitting Repeat pulses
module button_press_classifier
  import btn_pkg::*;
#(
  parameter int TICK_DIV     = 50000,
  parameter int LONG_TICKS   = 800,
  parameter int DOUBLE_TICKS = 250,
  parameter int REPEAT_TICKS = 150,
  parameter int CNT_W        = 16
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic Level,
  output logic Held,
  output logic ShortPress,
  output logic DoubleClick,
  output logic LongPress,
  output logic Repeat
);

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] DOUBLE_LAST = CNT_W'(DOUBLE_TICKS - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);

  logic tick;
  logic rise, fall;
  logic expire_long, expire_double, expire_repeat;

  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             prev_level_q;
  logic             held_q, held_d;
  logic             short_q, short_d;
  logic             double_q, double_d;
  logic             long_q, long_d;
  logic             repeat_q, repeat_d;

  tick_divider #(.DIV(TICK_DIV)) u_tick (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .Tick    (tick)
  );

  assign rise = Level & ~prev_level_q;
  assign fall = ~Level & prev_level_q;

  assign expire_long   = tick & (cnt_q == LONG_LAST);
  assign expire_double = tick & (cnt_q == DOUBLE_LAST);
  assign expire_repeat = tick & (cnt_q == REPEAT_LAST);

  // Edges are tested before expiries so an edge landing on the threshold wins.
  always_comb begin
    state_d  = state_q;
    short_d  = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    repeat_d = 1'b0;
    cnt_d    = (tick && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;

    case (state_q)
      IDLE: begin
        if (rise) state_d = PRESSED1;
      end
      PRESSED1: begin
        if (fall) begin
          state_d = WAIT2;
        end else if (expire_long) begin
          state_d = LONG_HELD;
          long_d  = 1'b1;
        end
      end
      WAIT2: begin
        if (rise) begin
          state_d  = PRESSED2;
          double_d = 1'b1;
        end else if (expire_double) begin
          state_d = IDLE;
          short_d = 1'b1;
        end
      end
      PRESSED2: begin
        if (fall) state_d = IDLE;
      end
      LONG_HELD: begin
        if (fall) begin
          state_d = IDLE;
        end else if (expire_repeat) begin
          repeat_d = 1'b1;
          cnt_d    = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) cnt_d = '0;

    held_d = state_is_held(state_d);
  end

  // PrevLevel resets high so a button held through reset needs a fresh press.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      prev_level_q <= 1'b1;
      held_q       <= 1'b0;
      short_q      <= 1'b0;
      double_q     <= 1'b0;
      long_q       <= 1'b0;
      repeat_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      prev_level_q <= Level;
      held_q       <= held_d;
      short_q      <= short_d;
      double_q     <= double_d;
      long_q       <= long_d;
      repeat_q     <= repeat_d;
    end
  end

  assign Held        = held_q;
  assign ShortPress  = short_q;
  assign DoubleClick = double_q;
  assign LongPress   = long_q;
  assign Repeat      = repeat_q;

endmodule

// File: tb/tb_button_press_classifier.sv
// Scoreboard bench for button_press_classifier with TICK_DIV=4, LONG_TICKS=10,
// DOUBLE_TICKS=5, REPEAT_TICKS=3. Expected events carry a kind and a cycle
// window [lo,hi]; an expiry N ticks after a transition edge e lands in
// [e+4N-3, e+4N] because the tick phase is unknown by up to one tick.
module tb_button_press_classifier;

  localparam logic [3:0] K_SHORT  = 4'b1000;
  localparam logic [3:0] K_DOUBLE = 4'b0100;
  localparam logic [3:0] K_LONG   = 4'b0010;
  localparam logic [3:0] K_REPEAT = 4'b0001;

  typedef struct {
    logic [3:0] kind;
    int         lo;
    int         hi;
    string      name;
  } exp_t;

  logic clk;
  logic rst_n;
  logic level;
  logic held, short_p, double_p, long_p, repeat_p;

  int   cyc = 0;
  int   rel = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  logic [3:0] prev_p = 4'b0;

  button_press_classifier #(
    .TICK_DIV     (4),
    .LONG_TICKS   (10),
    .DOUBLE_TICKS (5),
    .REPEAT_TICKS (3),
    .CNT_W        (16)
  ) dut (
    .Clk         (clk),
    .Reset_n     (rst_n),
    .Level       (level),
    .Held        (held),
    .ShortPress  (short_p),
    .DoubleClick (double_p),
    .LongPress   (long_p),
    .Repeat      (repeat_p)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // cyc: posedges so far; rel: posedges since reset release (ticks on rel%4==0)
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) rel <= 0;
    else        rel <= rel + 1;
  end

  // Monitor: pops one expectation per observed pulse.
  always @(negedge clk) begin
    logic [3:0] p;
    exp_t       e;
    p = {short_p, double_p, long_p, repeat_p};
    if (p != 4'b0) begin
      checks++;
      if (($countones(p) != 1) || ((p & prev_p) != 4'b0)) begin
        errors++;
        $display("FAIL pulse_shape: cyc=%0d pulses=%b prev=%b, required one-hot and 1 cycle wide",
                 cyc, p, prev_p);
      end
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: cyc=%0d pulses=%b, required no event", cyc, p);
      end else begin
        e = sb.pop_front();
        if ((p != e.kind) || (cyc < e.lo) || (cyc > e.hi)) begin
          errors++;
          $display("FAIL %s: got pulses=%b at cyc=%0d, required %b in [%0d,%0d]",
                   e.name, p, cyc, e.kind, e.lo, e.hi);
        end
      end
    end
    prev_p = p;
  end

  task automatic push(input logic [3:0] kind, input int lo, input int hi, input string name);
    exp_t e;
    e.kind = kind;
    e.lo   = lo;
    e.hi   = hi;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, required %b (cyc=%0d)", name, act, exp, cyc);
    end
  endtask

  // Stimulus is applied on negedges; the next posedge (cyc+1) samples it.
  initial begin
    int e, f, r;
    rst_n = 1'b0;
    level = 1'b0;
    wait_n(3);
    chk("reset_held", {3'b0, held}, 4'b0);
    chk("reset_pulses", {short_p, double_p, long_p, repeat_p}, 4'b0);
    rst_n = 1'b1;
    wait_n(8);

    // 1: short press of 3 ticks
    level = 1'b1;
    e = cyc + 1;
    wait_n(2);
    chk("short_held_high", {3'b0, held}, 4'b0001);
    wait_n(10);
    level = 1'b0;
    f = cyc + 1;
    push(K_SHORT, f + 17, f + 20, "short_press");
    wait_n(2);
    chk("short_held_low", {3'b0, held}, 4'b0);
    wait_n(40);

    // 2: double click
    level = 1'b1;
    wait_n(8);
    level = 1'b0;
    wait_n(8);
    level = 1'b1;
    r = cyc + 1;
    push(K_DOUBLE, r, r, "double_click");
    wait_n(2);
    chk("double_held_high", {3'b0, held}, 4'b0001);
    wait_n(6);
    level = 1'b0;
    wait_n(2);
    chk("double_held_low", {3'b0, held}, 4'b0);
    wait_n(40);

    // 3: hold 20 ticks -> LongPress then three Repeats
    level = 1'b1;
    e = cyc + 1;
    push(K_LONG,   e + 37, e + 40, "long_press");
    push(K_REPEAT, e + 49, e + 52, "repeat_1");
    push(K_REPEAT, e + 61, e + 64, "repeat_2");
    push(K_REPEAT, e + 73, e + 76, "repeat_3");
    wait_n(60);
    chk("long_held_high", {3'b0, held}, 4'b0001);
    wait_n(20);
    level = 1'b0;
    wait_n(2);
    chk("long_held_low", {3'b0, held}, 4'b0);
    wait_n(40);

    // 4: release exactly on the Expire(LONG) cycle; press edge on a tick edge
    while ((rel % 4) != 3) @(negedge clk);
    level = 1'b1;
    wait_n(40);
    level = 1'b0;
    f = cyc + 1;
    push(K_SHORT, f + 17, f + 20, "fall_at_expire_short");
    wait_n(40);

    // 5: reset during WAIT2, level held high across reset release
    level = 1'b1;
    wait_n(12);
    level = 1'b0;
    wait_n(6);
    rst_n = 1'b0;
    level = 1'b1;
    wait_n(3);
    chk("midreset_held", {3'b0, held}, 4'b0);
    rst_n = 1'b1;
    wait_n(60);
    chk("held_through_reset", {3'b0, held}, 4'b0);
    level = 1'b0;
    wait_n(20);
    level = 1'b1;
    wait_n(12);
    level = 1'b0;
    f = cyc + 1;
    push(K_SHORT, f + 17, f + 20, "post_reset_short");
    wait_n(40);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL missing_events: %0d expected events never seen, first is %s",
               sb.size(), sb[0].name);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
